// File: rtl/sand_brush_painter.sv
// sand_brush_painter: rasterizes a clipped, radius-clamped disc into grid cell writes
module sand_brush_painter #(
  parameter int GRID_W     = 160,
  parameter int GRID_H     = 120,
  parameter int MAX_RADIUS = 31,
  parameter int ADDR_W     = $clog2(GRID_W * GRID_H)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        brush_x,
  input  logic [7:0]        brush_y,
  input  logic [7:0]        brush_radius,
  input  logic [1:0]        brush_type,
  output logic              cell_we,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [1:0]        cell_data,
  input  logic              cell_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic signed [9:0] GW   = 10'(GRID_W);
  localparam logic signed [9:0] GH   = 10'(GRID_H);
  localparam logic [7:0]        RMAX = 8'(MAX_RADIUS);
  state_t state, state_nx;
  logic [7:0] cx, cy, r, r_in;
  logic [1:0] t;
  logic signed [9:0] dx, dy, rs, rin_s, px, py;
  logic [8:0] ax, ay;
  logic [17:0] dist2, r2;
  logic valid, adv, last;
  // current candidate geometry: disc membership, clipping and advance condition
  always_comb begin
    r_in  = brush_radius > RMAX ? RMAX : brush_radius;
    rin_s = {2'b00, r_in};
    rs    = {2'b00, r};
    px    = {2'b00, cx} + dx;
    py    = {2'b00, cy} + dy;
    ax    = dx[9] ? 9'(-dx) : dx[8:0];
    ay    = dy[9] ? 9'(-dy) : dy[8:0];
    dist2 = 18'(ax) * 18'(ax) + 18'(ay) * 18'(ay);
    r2    = 18'(r) * 18'(r);
    valid = state == SCAN && dist2 <= r2 && !px[9] && px < GW && !py[9] && py < GH;
    adv   = state == SCAN && (!valid || cell_ready);
    last  = dx == rs && dy == rs;
  end
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // next state and register-only outputs
  always_comb begin
    state_nx  = state == IDLE ? (start ? SCAN : IDLE) :
                state == SCAN ? (adv && last ? DONE : SCAN) : IDLE;
    busy      = state != IDLE;
    done      = state == DONE;
    cell_we   = valid;
    cell_addr = valid ? ADDR_W'(py[8:0]) * ADDR_W'(GRID_W) + ADDR_W'(px[8:0]) : '0;
    cell_data = valid ? t : 2'd0;
  end
  // brush latch at stroke start, then row-major offset walk
  always_ff @(posedge clock) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
      r  <= '0;
      t  <= '0;
      dx <= '0;
      dy <= '0;
    end else if (state == IDLE && start) begin
      cx <= brush_x;
      cy <= brush_y;
      r  <= r_in;
      t  <= brush_type;
      dx <= -rin_s;
      dy <= -rin_s;
    end else if (adv) begin
      dx <= dx == rs ? -rs : dx + 10'sd1;
      dy <= dx == rs ? dy + 10'sd1 : dy;
    end
  end
endmodule

// File: tb/tb_sand_brush_painter.sv
// tb_sand_brush_painter: directed checks of stroke rasterization, clipping, backpressure and reset
module tb_sand_brush_painter;
  logic clock = 0, reset = 1, start = 0, cell_ready = 1;
  logic [7:0] brush_x = 0, brush_y = 0, brush_radius = 0;
  logic [1:0] brush_type = 0;
  logic cell_we, busy, done;
  logic [14:0] cell_addr;
  logic [1:0] cell_data;
  int tests = 0, fails = 0, cyc = 0, e0 = 0, done_edge = 0, done_cnt = 0, busy_cnt = 0;
  logic [14:0] wa[$];
  logic [1:0] wd[$];
  int wedge[$];

  sand_brush_painter dut (
    .clock(clock), .reset(reset), .start(start),
    .brush_x(brush_x), .brush_y(brush_y), .brush_radius(brush_radius), .brush_type(brush_type),
    .cell_we(cell_we), .cell_addr(cell_addr), .cell_data(cell_data), .cell_ready(cell_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // record accepted writes, done pulses and busy cycles, tagged by the edge that samples them
  always @(negedge clock) begin
    if (cell_we && cell_ready) begin
      wa.push_back(cell_addr);
      wd.push_back(cell_data);
      wedge.push_back(cyc + 1);
    end
    if (done) begin
      done_cnt++;
      done_edge = cyc + 1;
    end
    if (busy) busy_cnt++;
  end

  task automatic go(input logic [7:0] x, input logic [7:0] y, input logic [7:0] rad, input logic [1:0] ty);
    @(posedge clock); #1;
    wa.delete(); wd.delete(); wedge.delete();
    done_cnt = 0; busy_cnt = 0; done_edge = 0;
    brush_x = x; brush_y = y; brush_radius = rad; brush_type = ty;
    start = 1;
    e0 = cyc + 1;
    @(posedge clock); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    tests++;
    if (done_cnt == 0) begin
      fails++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    tests++; if (cell_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", cell_we); end
    tests++; if (cell_addr !== 15'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", cell_addr); end
    tests++; if (cell_data !== 2'd0) begin fails++; $display("FAIL reset_data: got %0d expected 0", cell_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    reset = 0;
  endtask

  task automatic test_r0;
    go(10, 20, 0, 2);
    wait_done(10, "r0");
    tests++; if (wa.size() != 1) begin fails++; $display("FAIL r0_count: got %0d expected 1", wa.size()); end
    if (wa.size() > 0) begin
      tests++; if (wa[0] !== 15'd3210) begin fails++; $display("FAIL r0_addr: got %0d expected 3210", wa[0]); end
      tests++; if (wd[0] !== 2'd2) begin fails++; $display("FAIL r0_data: got %0d expected 2", wd[0]); end
      tests++; if (wedge[0] != e0 + 1) begin fails++; $display("FAIL r0_write_time: got E0+%0d expected E0+1", wedge[0] - e0); end
    end
    tests++; if (done_edge != e0 + 2) begin fails++; $display("FAIL r0_done_time: got E0+%0d expected E0+2", done_edge - e0); end
    tests++; if (busy_cnt != 2) begin fails++; $display("FAIL r0_busy_cycles: got %0d expected 2", busy_cnt); end
  endtask

  task automatic test_r1;
    int exp_a[5] = '{645, 804, 805, 806, 965};
    go(5, 5, 1, 1);
    wait_done(20, "r1");
    tests++; if (wa.size() != 5) begin fails++; $display("FAIL r1_count: got %0d expected 5", wa.size()); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= wa.size() || wa[i] !== 15'(exp_a[i]) || wd[i] !== 2'd1) begin
        fails++;
        $display("FAIL r1_write%0d: got addr %0d data %0d expected addr %0d data 1", i,
                 i < wa.size() ? wa[i] : 15'h7fff, i < wd.size() ? wd[i] : 2'd0, exp_a[i]);
      end
    end
    tests++; if (done_edge != e0 + 10) begin fails++; $display("FAIL r1_done_time: got E0+%0d expected E0+10", done_edge - e0); end
  endtask

  task automatic test_clip;
    int exp_a[6] = '{0, 1, 2, 160, 161, 320};
    go(0, 0, 2, 3);
    wait_done(40, "clip");
    tests++; if (wa.size() != 6) begin fails++; $display("FAIL clip_count: got %0d expected 6", wa.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= wa.size() || wa[i] !== 15'(exp_a[i]) || wd[i] !== 2'd3) begin
        fails++;
        $display("FAIL clip_write%0d: got addr %0d data %0d expected addr %0d data 3", i,
                 i < wa.size() ? wa[i] : 15'h7fff, i < wd.size() ? wd[i] : 2'd0, exp_a[i]);
      end
    end
    tests++; if (done_edge != e0 + 26) begin fails++; $display("FAIL clip_done_time: got E0+%0d expected E0+26", done_edge - e0); end
  endtask

  task automatic test_backpressure;
    cell_ready = 0;
    go(10, 20, 0, 2);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) cell_ready = 1;
      tests++;
      if (cell_we !== 1'b1 || cell_addr !== 15'd3210 || cell_data !== 2'd2) begin
        fails++;
        $display("FAIL bp_hold%0d: got we %b addr %0d data %0d expected we 1 addr 3210 data 2", i, cell_we, cell_addr, cell_data);
      end
      @(posedge clock); #1;
    end
    wait_done(10, "bp");
    tests++; if (wa.size() != 1) begin fails++; $display("FAIL bp_count: got %0d expected 1", wa.size()); end
    tests++; if (done_edge != e0 + 5) begin fails++; $display("FAIL bp_done_time: got E0+%0d expected E0+5", done_edge - e0); end
  endtask

  task automatic test_back_to_back;
    go(5, 5, 1, 1);
    repeat (2) @(posedge clock);
    #1;
    brush_x = 0; brush_y = 0; brush_radius = 2; brush_type = 3;
    start = 1;
    @(posedge clock); #1;
    start = 0;
    wait_done(20, "busy_start");
    tests++; if (wa.size() != 5) begin fails++; $display("FAIL busy_start_count: got %0d expected 5", wa.size()); end
    if (wa.size() == 5) begin
      tests++; if (wa[0] !== 15'd645 || wa[4] !== 15'd965) begin fails++; $display("FAIL busy_start_addrs: got %0d..%0d expected 645..965", wa[0], wa[4]); end
    end
    @(posedge clock); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_start_queued: got busy %b expected 0", busy); end
    go(5, 5, 1, 1);
    repeat (3) @(posedge clock);
    #1;
    tests++; if (cell_we !== 1'b1) begin fails++; $display("FAIL midscan_we: got %b expected 1", cell_we); end
    reset = 1;
    @(posedge clock); #1;
    tests++;
    if (cell_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midscan_reset: got we %b busy %b done %b expected 0 0 0", cell_we, busy, done);
    end
    reset = 0;
    go(10, 20, 0, 2);
    wait_done(10, "after_reset");
    tests++;
    if (wa.size() != 1 || wa[0] !== 15'd3210 || done_edge != e0 + 2) begin
      fails++;
      $display("FAIL after_reset: got %0d writes, done at E0+%0d expected 1 write to 3210, done at E0+2", wa.size(), done_edge - e0);
    end
  endtask

  task automatic test_clamp_offgrid;
    go(80, 60, 200, 1);
    wait_done(4100, "clamp");
    tests++; if (done_edge != e0 + 1 + 3969) begin fails++; $display("FAIL clamp_done_time: got E0+%0d expected E0+3970", done_edge - e0); end
    tests++; if (wa.size() == 0) begin fails++; $display("FAIL clamp_count: got 0 writes expected nonzero"); end
    if (wa.size() > 0) begin
      tests++; if (wa[0] !== 15'd4720) begin fails++; $display("FAIL clamp_first: got %0d expected 4720", wa[0]); end
      tests++; if (wa[wa.size() - 1] !== 15'd14640) begin fails++; $display("FAIL clamp_last: got %0d expected 14640", wa[wa.size() - 1]); end
    end
    go(200, 200, 3, 2);
    wait_done(60, "offgrid");
    tests++; if (wa.size() != 0) begin fails++; $display("FAIL offgrid_count: got %0d expected 0", wa.size()); end
    tests++; if (done_edge != e0 + 50) begin fails++; $display("FAIL offgrid_done_time: got E0+%0d expected E0+50", done_edge - e0); end
  endtask

  initial begin
    test_reset();
    test_r0();
    test_r1();
    test_clip();
    test_backpressure();
    test_back_to_back();
    test_clamp_offgrid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sand_brush_painter.md
# sand_brush_painter

Rasterizes one brush stroke into the sand cell grid. The HPS-facing register block latches brush x, y, radius and particle type. On a start strobe, this block walks the disc of that radius centred on (x, y), clips it to the grid, and issues one cell write per covered cell into the grid memory write port. It is the consumer of the brush registers and sits between them and the grid RAM, sharing that RAM's write port under a ready/valid handshake.

## Interface
- GRID_W, default 160: grid width in cells.
- GRID_H, default 120: grid height in cells.
- MAX_RADIUS, default 31: larger requested radii are clamped to this value.
- ADDR_W, default $clog2(GRID_W*GRID_H): width of the cell address.
- clock  in  1  sole clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle strobe requesting a stroke; only honoured in IDLE.
- brush_x, brush_y  in  8 each  disc centre in cells; unsigned; may lie off-grid.
- brush_radius  in  8  disc radius in cells; unsigned.
- brush_type  in  2  particle type written to every covered cell; 0 = empty (erase).
- cell_we  out  1  write valid.
- cell_addr  out  ADDR_W  row-major address, y*GRID_W + x.
- cell_data  out  2  value to write.
- cell_ready  in  1  the grid memory accepts the write in any cycle where cell_we && cell_ready.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a stroke finishes.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE → SCAN on start.
  - Latch cx=brush_x, cy=brush_y, t=brush_type, r=min(brush_radius, MAX_RADIUS).
  - Initialise offsets dx=dy=-r.
- SCAN: one candidate (dx, dy) is current per cycle.
  - Scan order is row-major: dy outer, dx inner, each running -r..+r.
  - Arithmetic is 10-bit signed for px=cx+dx and py=cy+dy; squares/sums are 18-bit unsigned.
  - A candidate is valid iff dx²+dy² ≤ r², 0 ≤ px < GRID_W and 0 ≤ py < GRID_H.
  - Valid candidate: cell_we=1, cell_addr=py*GRID_W+px, cell_data=t. The candidate is held until cell_ready; it advances in the cycle the write is accepted.
  - Invalid candidate: cell_we=0; advance next cycle.
  - After candidate (r, r) advances → DONE.
- DONE: done=1 and busy=1 for one cycle, then → IDLE.
- start in SCAN or DONE is ignored and not queued.
- Brush inputs are sampled only at the accepting edge. Later changes do not affect the stroke in flight.
- r=0 yields exactly the centre cell, if it is on-grid.
- A fully off-grid disc produces zero writes but still scans and pulses done.
- cell_we, cell_addr and cell_data depend only on registers; there is no combinational path from start, brush_* or cell_ready.
- cell_addr and cell_data are stable while cell_we=1 && !cell_ready.

## Timing
- Reset values: cell_we=0, cell_addr=0, cell_data=0, busy=0, done=0, state=IDLE.
- Reset takes priority over everything:
  - Reset asserted mid-SCAN drops cell_we and busy at the following edge.
  - Writes not yet accepted are abandoned.
- Latency, with start sampled at edge E0:
  - busy=1 and the first candidate appear at E0+1.
  - With cell_ready held high, SCAN lasts exactly (2r+1)² cycles.
  - done is high in cycle E0+1+(2r+1)².
  - busy falls the cycle after done.
  - Each low-ready cycle on a valid candidate extends SCAN by one cycle.
- Throughput: at most one write per cycle. The earliest next start is accepted in the cycle after done (back in IDLE).

## Test plan
- r=0 at (10,20), type 2, ready high:
  - Exactly one write: addr 3210, data 2, in cycle E0+1.
  - done in cycle E0+2; busy high for 2 cycles.
- r=1 at (5,5), type 1:
  - 9 SCAN cycles.
  - Writes in order to addrs 645, 804, 805, 806, 965; corners skipped.
  - done at E0+10.
- r=2 at (0,0), type 3 (clipping):
  - 25 SCAN cycles.
  - Exactly 6 writes, to addrs 0, 1, 2, 160, 161, 320.
  - No negative or wrapped addresses.
- Backpressure, r=0 at (10,20):
  - Hold cell_ready low for 3 cycles, then high.
  - cell_we stays high with addr 3210 / data constant for 4 cycles.
  - done at E0+5.
- Start while busy, then reset:
  - A second start during SCAN is ignored: write count and addresses match the first stroke only.
  - Reset asserted mid-SCAN gives cell_we=0, busy=0, done=0 next cycle.
  - A fresh start afterwards runs normally.
- Clamp and off-grid:
  - brush_radius=200 at (80,60) scans (63)²=3969 cycles; the farthest writes sit at dy=±31.
  - Centre (200,200), r=3: zero writes, done still pulses after 49 cycles.
